// File: rtl/alu_core_pkg.sv
// Shared constants for the ALU: datapath width, main-decoder classes,
// instruction opcodes (bits [31:21]) and the 4-bit ALU control codes.
package alu_core_pkg;

  localparam int WORD = 64;

  localparam logic [1:0] ALUOP_DTYPE  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_ORR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_PASS = 4'b0111;

endpackage

// File: rtl/alu_core_control.sv
// ALU control decoder: main-decoder class plus opcode -> 4-bit operation.
// Anything not explicitly decoded falls back to add.
module alu_control
  import alu_core_pkg::*;
(
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output logic [3:0]  control_bits
);

  always_comb begin
    control_bits = CTRL_ADD;
    case (alu_op)
      ALUOP_DTYPE:  control_bits = CTRL_ADD;
      ALUOP_BRANCH: control_bits = CTRL_PASS;
      ALUOP_RTYPE: begin
        case (opcode)
          OP_ADD:  control_bits = CTRL_ADD;
          OP_SUB:  control_bits = CTRL_SUB;
          OP_AND:  control_bits = CTRL_AND;
          OP_ORR:  control_bits = CTRL_ORR;
          default: control_bits = CTRL_ADD;
        endcase
      end
      default: control_bits = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Single-cycle ALU: combinational result/zero flag with a registered copy
// of both, cleared asynchronously by rst_n.
module alu_core #(
  parameter int WORD = alu_core_pkg::WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WORD-1:0] data_1,
  input  logic [WORD-1:0] data_2,
  input  logic [1:0]      alu_op,
  input  logic [10:0]     opcode,
  output logic [3:0]      control,
  output logic [WORD-1:0] result,
  output logic            flag,
  output logic [WORD-1:0] result_q,
  output logic            flag_q
);
  import alu_core_pkg::*;

  alu_control u_ctrl (
    .alu_op       (alu_op),
    .opcode       (opcode),
    .control_bits (control)
  );

  // Undecoded control values yield zero, which forces the zero flag high.
  always_comb begin
    result = '0;
    case (control)
      CTRL_ADD:  result = data_1 + data_2;
      CTRL_SUB:  result = data_1 - data_2;
      CTRL_AND:  result = data_1 & data_2;
      CTRL_ORR:  result = data_1 | data_2;
      CTRL_PASS: result = data_2;
      default:   result = '0;
    endcase
  end

  assign flag = (result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      result_q <= result;
      flag_q   <= flag;
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner cases plus random
// vectors compared against an arithmetic reference model.
module tb_alu_core;
  localparam int W = 64;

  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;
  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_CBZ  = 11'b10110100000;
  localparam logic [10:0] T_B    = 11'b00010100000;

  logic          clk, rst_n;
  logic [W-1:0]  data_1, data_2;
  logic [1:0]    alu_op;
  logic [10:0]   opcode;
  logic [3:0]    control;
  logic [W-1:0]  result, result_q;
  logic          flag, flag_q;

  int n_vec = 0;
  int n_bad = 0;

  alu_core #(.WORD(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_1   (data_1),
    .data_2   (data_2),
    .alu_op   (alu_op),
    .opcode   (opcode),
    .control  (control),
    .result   (result),
    .flag     (flag),
    .result_q (result_q),
    .flag_q   (flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: operation chosen by name, result from plain arithmetic.
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [10:0] opc);
    if (op == 2'b01) return 4'b0111;
    if (op == 2'b10) begin
      if (opc == T_SUB) return 4'b0110;
      if (opc == T_AND) return 4'b0000;
      if (opc == T_ORR) return 4'b0001;
    end
    return 4'b0010;
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'b0010: return a + b;
      4'b0110: return a + (~b) + 1'b1;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0111: return b;
      default: return '0;
    endcase
  endfunction

  // Drive after the falling edge, check combinational outputs, then the
  // registered copy after the next rising edge.
  task automatic apply(input string tag, input logic [1:0] op, input logic [10:0] opc,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0]   ec;
    logic [W-1:0] er;
    @(negedge clk);
    alu_op = op; opcode = opc; data_1 = a; data_2 = b;
    ec = ref_ctrl(op, opc);
    er = ref_res(ec, a, b);
    #1;
    chk({tag, ".control"}, W'(control), W'(ec));
    chk({tag, ".result"}, result, er);
    chk({tag, ".flag"}, W'(flag), W'(er == '0));
    @(posedge clk); #1;
    chk({tag, ".result_q"}, result_q, er);
    chk({tag, ".flag_q"}, W'(flag_q), W'(er == '0));
  endtask

  initial begin
    logic [10:0] opc_tab [8];
    logic [10:0] opc;
    logic [W-1:0] a, b;
    logic [W-1:0] ones;
    opc_tab = '{T_ADD, T_SUB, T_AND, T_ORR, T_LDUR, T_STUR, T_CBZ, T_B};
    ones = '1;

    rst_n = 1'b0;
    alu_op = 2'b10; opcode = T_ADD; data_1 = 15; data_2 = 10;
    #1;
    chk("reset.result_q", result_q, '0);
    chk("reset.flag_q", W'(flag_q), '0);
    chk("reset.comb_result", result, 64'd25);
    @(negedge clk); rst_n = 1'b1;

    apply("add", 2'b10, T_ADD, 15, 10);
    apply("sub", 2'b10, T_SUB, 15, 10);
    apply("and", 2'b10, T_AND, 15, 10);
    apply("orr", 2'b10, T_ORR, 15, 10);
    apply("ldur", 2'b00, T_LDUR, 15, 10);
    apply("stur", 2'b00, T_STUR, 15, 10);
    apply("cbz", 2'b01, T_CBZ, 15, 10);
    apply("b", 2'b01, T_B, 15, 10);
    apply("sub_eq", 2'b10, T_SUB, 15, 15);
    apply("add_eq", 2'b10, T_ADD, 15, 15);
    apply("cbz_taken", 2'b01, T_CBZ, 15, 0);
    apply("wrap_add", 2'b10, T_ADD, ones, 1);
    apply("wrap_sub", 2'b10, T_SUB, 0, 1);
    apply("rtype_other", 2'b10, 11'h7FF, 5, 7);
    apply("reserved", 2'b11, T_SUB, 20, 3);

    // Spot checks of absolute values independent of the model.
    @(negedge clk); alu_op = 2'b10; opcode = T_SUB; data_1 = 15; data_2 = 10; #1;
    chk("abs.sub", result, 64'd5);
    @(negedge clk); alu_op = 2'b10; opcode = T_SUB; data_1 = 0; data_2 = 1; #1;
    chk("abs.wrap_sub", result, ones);
    chk("abs.wrap_flag", W'(flag), '0);

    // Asynchronous reset mid-cycle with a non-zero result registered.
    apply("pre_rst", 2'b10, T_ADD, 15, 10);
    #2; rst_n = 1'b0; #1;
    chk("rst.result_q", result_q, '0);
    chk("rst.flag_q", W'(flag_q), '0);
    chk("rst.result", result, 64'd25);
    chk("rst.control", W'(control), 64'd2);
    @(posedge clk); #1;
    chk("rst_held.result_q", result_q, '0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel.result_q", result_q, '0);
    @(posedge clk); #1;
    chk("rel.reload", result_q, 64'd25);
    chk("rel.flag_q", W'(flag_q), '0);

    for (int i = 0; i < 300; i++) begin
      opc = ($urandom_range(0, 3) == 0) ? 11'($urandom) : opc_tab[$urandom_range(0, 7)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = '0;
        2: a = '1;
        default: ;
      endcase
      apply("rand", 2'($urandom_range(0, 3)), opc, a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 Parameter WORD, default 64, data path width in bits.
REQ-002 clk  input  1  rising-edge clock for registered outputs.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data_1  input  WORD  operand A (first register read).
REQ-005 data_2  input  WORD  operand B (second register read or immediate).
REQ-006 alu_op  input  2  main-decoder class: 00 D-type, 01 branch, 10 R-type, 11 reserved.
REQ-007 opcode  input  11  instruction bits [31:21].
REQ-008 control  output  4  decoded ALU operation code.
REQ-009 result  output  WORD  combinational ALU result.
REQ-010 flag  output  1  combinational zero flag, 1 when result equals 0.
REQ-011 result_q  output  WORD  registered copy of result.
REQ-012 flag_q  output  1  registered copy of flag.

Function
REQ-013 control SHALL be purely combinational from alu_op and opcode.
REQ-014 alu_op 00 (LDUR/STUR) SHALL give control 0010 (add), ignoring opcode.
REQ-015 alu_op 01 (CBZ/B) SHALL give control 0111 (pass data_2), ignoring opcode.
REQ-016 alu_op 10 SHALL decode: 10001011000 ADD->0010, 11001011000 SUB->0110, 10001010000 AND->0000, 10101010000 ORR->0001.
REQ-017 alu_op 10 with any other opcode SHALL give 0010.
REQ-018 alu_op 11 SHALL give 0010.
REQ-019 Control 0010: result = data_1 + data_2 modulo 2^WORD; carry discarded.
REQ-020 Control 0110: result = data_1 - data_2 modulo 2^WORD; borrow discarded.
REQ-021 Control 0000: bitwise AND; 0001: bitwise OR.
REQ-022 Control 0111: result = data_2 unchanged.
REQ-023 Any other control value SHALL give result 0 and flag 1.
REQ-024 flag SHALL be 1 exactly when all WORD bits of result are 0, in every operation.
REQ-025 result and flag SHALL settle in the same cycle as their inputs; zero-cycle latency.
REQ-026 result_q and flag_q SHALL capture result and flag on each rising clk edge; one-cycle latency.
REQ-027 There are no handshakes or stall inputs; a new operation is accepted every cycle.

Reset
REQ-028 rst_n low SHALL immediately clear result_q to 0 and flag_q to 0, regardless of clk.
REQ-029 Combinational outputs control, result and flag SHALL be unaffected by rst_n.
REQ-030 The first rising edge after rst_n deasserts SHALL load the then-current result and flag.
REQ-031 rst_n asserted mid-operation SHALL discard the in-flight registered value; no other state exists.

Structure
REQ-032 A shared package SHALL hold WORD, the 2-bit ALUOp constants (00/01/10), the 11-bit opcodes (ADD, SUB, AND, ORR, LDUR, STUR), and the 4-bit control codes (0010, 0110, 0000, 0001, 0111).
REQ-033 Decoding SHALL be a sub-module named alu_control (alu_op, opcode -> control_bits); the datapath and output registers stay in alu_core.
REQ-034 The clock generator oscillator is a simulation-only model producing clk with a 10 ns period and 50% duty cycle; it is not part of synthesizable RTL.

Verification
REQ-035 data_1=15, data_2=10, alu_op=10: ADD->25/flag 0, SUB->5, AND->10, ORR->15; result_q follows one edge later.
REQ-036 data_1=15, data_2=10, alu_op=00 with LDUR or STUR: control 0010, result 25; alu_op=01 with the CBZ or B pattern: control 0111, result 10, flag 0.
REQ-037 data_1=15, data_2=15, alu_op=10, SUB: result 0, flag 1; then ADD: result 30, flag 0.
REQ-038 data_1=15, data_2=0, alu_op=01: result 0, flag 1 (CBZ taken).
REQ-039 Wrap: data_1 all-ones, data_2=1, ADD -> result 0, flag 1; data_1=0, data_2=1, SUB -> all-ones, flag 0.
REQ-040 Assert rst_n low between clk edges while result is non-zero: result_q=0 and flag_q=0 immediately, while result stays valid; after release the next edge reloads result_q.
